lcd_write_scheduler: RTL and testbench

Buffers character writes issued by the processor's LCD instruction and schedules them onto the 10-bit LCD driver bus one at a time. Each write waits for the driver's ready state, so back-to-back processor writes are never lost or overlapped. It sits between the processor core's LCD enable/data outputs and the LCD driver. It replaces the single-shot IDLE/LETTER handshake with a FIFO plus a busy/ready tracking FSM.

---
 rtl/lcd_write_scheduler_if.sv | 26 ++
 rtl/lcd_write_scheduler.sv | 118 +++++++++++
 tb/tb_lcd_write_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_scheduler_if.sv
// Processor-to-LCD write bundle: write port, driver state in, bus and status out.
interface lcd_write_scheduler_if #(
   parameter int DEPTH = 8
);
   logic                     wr_en;
   logic [7:0]               wr_data;
   logic [7:0]               LCD_STATE;
   logic [9:0]               LCD_INPUT_BUS;
   logic                     full;
   logic [$clog2(DEPTH):0]   count;
   logic                     busy;
   logic                     overflow;
   logic                     timeout_err;

   modport master (
      output wr_en, wr_data, LCD_STATE,
      input  LCD_INPUT_BUS, full, count,
      input  busy, overflow, timeout_err
   );

   modport slave (
      input  wr_en, wr_data, LCD_STATE,
      output LCD_INPUT_BUS, full, count,
      output busy, overflow, timeout_err
   );
endinterface

// File: rtl/lcd_write_scheduler.sv
// Queues processor LCD writes and issues them one at a time
// to the LCD driver, waiting for its busy/ready cycle between writes.
module lcd_write_scheduler #(
   parameter int         DEPTH       = 8,
   parameter logic [7:0] READY_CODE  = 8'd4,
   parameter int         ACK_TIMEOUT = 16
) (
   input logic clk,
   input logic reset,
   lcd_write_scheduler_if.slave lcd
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_READY
   } state_t;

   state_t          state, state_n;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   cnt;
   logic [TW-1:0]   tmr, tmr_n;
   logic            lcd_en, lcd_en_n;
   logic [7:0]      lcd_data, lcd_data_n;
   logic            ovf;
   logic            terr, terr_n;
   logic            ready, empty, full_i;
   logic            push, pop;

   assign ready  = (lcd.LCD_STATE == READY_CODE);
   assign empty  = (cnt == '0);
   assign full_i = (cnt == CW'(DEPTH));
   assign push   = lcd.wr_en && !full_i;

   always_comb begin
      state_n    = state;
      tmr_n      = tmr;
      lcd_en_n   = lcd_en;
      lcd_data_n = lcd_data;
      terr_n     = terr;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && ready) begin
               state_n    = ISSUE;
               lcd_en_n   = 1'b1;
               lcd_data_n = mem[rd_ptr];
               pop        = 1'b1;
            end
         end
         ISSUE: begin
            lcd_en_n = 1'b0;
            tmr_n    = '0;
            state_n  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!ready) begin
               state_n = WAIT_READY;
            end else if (tmr == TW'(ACK_TIMEOUT - 1)) begin
               // Driver never acknowledged; treat the byte as consumed.
               terr_n  = 1'b1;
               state_n = IDLE;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         WAIT_READY: begin
            if (ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         tmr      <= '0;
         lcd_en   <= 1'b0;
         lcd_data <= '0;
         ovf      <= 1'b0;
         terr     <= 1'b0;
      end else begin
         state    <= state_n;
         tmr      <= tmr_n;
         lcd_en   <= lcd_en_n;
         lcd_data <= lcd_data_n;
         terr     <= terr_n;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         // Full is judged before the edge, so a same-edge pop does not help.
         if (lcd.wr_en && full_i) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr] <= lcd.wr_data;
   end

   assign lcd.LCD_INPUT_BUS = {lcd_en, lcd_data, reset};
   assign lcd.full          = full_i;
   assign lcd.count         = cnt;
   assign lcd.busy          = (state != IDLE) || !empty;
   assign lcd.overflow      = ovf;
   assign lcd.timeout_err   = terr;
endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Scoreboard bench for lcd_write_scheduler with a simple LCD driver model.
module tb_lcd_write_scheduler;
   logic clk;
   logic reset;

   lcd_write_scheduler_if #(.DEPTH(8)) lif ();

   lcd_write_scheduler #(
      .DEPTH(8),
      .READY_CODE(8'd4),
      .ACK_TIMEOUT(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .lcd(lif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         tests_run;
   int         tests_failed;
   int         cyc;
   int         pulses;
   int         prev_cyc;
   int         last_cyc;
   int         err_cyc;
   int         peak;
   int         busy_time;
   int         bcnt;
   int         wcyc;
   int         base;
   bit         err_seen;
   bit         prev_en;
   bit         drv_normal;
   logic [7:0] man_state;
   logic [7:0] q [$];

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      logic       en;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         en = lif.LCD_INPUT_BUS[9];
         if (!reset && lif.count > peak) peak = lif.count;
         if (lif.timeout_err === 1'b1 && !err_seen) begin
            err_seen = 1'b1;
            err_cyc  = cyc;
         end
         if (en === 1'b1) begin
            check("en_ready", lif.LCD_STATE, 32'd4);
            check("en_single", prev_en, 32'd0);
            if (q.size() == 0) begin
               check("extra_pulse", lif.LCD_INPUT_BUS, 32'd0);
            end else begin
               e = q.pop_front();
               check("pulse_data", lif.LCD_INPUT_BUS, {22'd0, 1'b1, e, 1'b0});
            end
            pulses++;
            prev_cyc = last_cyc;
            last_cyc = cyc;
         end
         prev_en = (en === 1'b1);
         // Driver model: busy for busy_time cycles after each strobe.
         if (!drv_normal) begin
            lif.LCD_STATE = man_state;
         end else if (en === 1'b1) begin
            lif.LCD_STATE = 8'd2;
            bcnt = busy_time;
         end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) lif.LCD_STATE = 8'd4;
         end else begin
            lif.LCD_STATE = 8'd4;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      lif.wr_en = 1'b0;
      @(posedge clk); #1;
      check("rst_bit0", lif.LCD_INPUT_BUS[0], 32'd1);
      reset = 1'b0;
      q.delete();
      err_seen = 1'b0;
      #1;
      check("rst_bus", lif.LCD_INPUT_BUS, 32'd0);
      check("rst_count", lif.count, 32'd0);
      check("rst_full", lif.full, 32'd0);
      check("rst_busy", lif.busy, 32'd0);
      check("rst_ovf", lif.overflow, 32'd0);
      check("rst_terr", lif.timeout_err, 32'd0);
   endtask

   task automatic write_byte(input logic [7:0] d, input bit drop);
      @(posedge clk); #1;
      lif.wr_en   = 1'b1;
      lif.wr_data = d;
      if (!drop) q.push_back(d);
      wcyc = cyc + 1;
   endtask

   task automatic end_write();
      @(posedge clk); #1;
      lif.wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(posedge clk); #1;
         if (!lif.busy && q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check("idle_wait", done, 32'd1);
   endtask

   initial begin
      int w;
      logic [7:0] burst [5];
      burst = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      tests_run = 0;
      tests_failed = 0;
      cyc = 0;
      pulses = 0;
      prev_cyc = 0;
      last_cyc = 0;
      err_cyc = 0;
      peak = 0;
      bcnt = 0;
      prev_en = 1'b0;
      err_seen = 1'b0;
      reset = 1'b1;
      lif.wr_en = 1'b0;
      lif.wr_data = 8'h00;
      man_state = 8'd4;
      drv_normal = 1'b1;
      busy_time = 3;
      fork
         monitor();
         begin
            #200000;
            $display("FAIL watchdog: got timeout expected finish");
            $fatal(1, "watchdog");
         end
      join_none

      // Single write
      do_reset();
      base = pulses;
      write_byte(8'h41, 1'b0);
      w = wcyc;
      end_write();
      wait_idle(50);
      check("t1_pulses", pulses - base, 32'd1);
      check("t1_latency", last_cyc - w, 32'd2);
      check("t1_count", lif.count, 32'd0);
      check("t1_busy", lif.busy, 32'd0);

      // Burst against a slow driver
      busy_time = 10;
      do_reset();
      base = pulses;
      peak = 0;
      for (int i = 0; i < 5; i++) write_byte(burst[i], 1'b0);
      end_write();
      wait_idle(300);
      check("t2_pulses", pulses - base, 32'd5);
      check("t2_peak", peak, 32'd4);

      // Overflow with a stuck driver
      drv_normal = 1'b0;
      man_state = 8'd0;
      do_reset();
      base = pulses;
      for (int i = 0; i < 8; i++) write_byte(8'h30 + 8'(i), 1'b0);
      write_byte(8'h39, 1'b1);
      check("t3_full8", lif.full, 32'd1);
      check("t3_ovf8", lif.overflow, 32'd0);
      end_write();
      check("t3_full", lif.full, 32'd1);
      check("t3_ovf", lif.overflow, 32'd1);
      check("t3_count", lif.count, 32'd8);
      busy_time = 3;
      drv_normal = 1'b1;
      wait_idle(300);
      check("t3_pulses", pulses - base, 32'd8);

      // Push and pop on the same edge while full
      drv_normal = 1'b0;
      man_state = 8'd0;
      do_reset();
      base = pulses;
      for (int i = 0; i < 8; i++) write_byte(8'h60 + 8'(i), 1'b0);
      end_write();
      @(posedge clk); #1;
      man_state = 8'd4;
      lif.wr_en = 1'b1;
      lif.wr_data = 8'hEE;
      @(posedge clk); #1;
      lif.wr_en = 1'b0;
      man_state = 8'd2;
      check("t4_count", lif.count, 32'd7);
      check("t4_ovf", lif.overflow, 32'd1);
      check("t4_full", lif.full, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      busy_time = 3;
      drv_normal = 1'b1;
      wait_idle(300);
      check("t4_pulses", pulses - base, 32'd8);

      // Timeout: driver never leaves READY_CODE
      drv_normal = 1'b0;
      man_state = 8'd4;
      do_reset();
      base = pulses;
      write_byte(8'h54, 1'b0);
      write_byte(8'h4F, 1'b0);
      end_write();
      wait_idle(100);
      check("t5_pulses", pulses - base, 32'd2);
      check("t5_err", err_seen, 32'd1);
      check("t5_err_time", err_cyc - prev_cyc, 32'd17);
      check("t5_next_issue", last_cyc - prev_cyc, 32'd18);

      // Reset during WAIT_READY with entries queued
      busy_time = 10;
      drv_normal = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) write_byte(8'h70 + 8'(i), 1'b0);
      end_write();
      check("t6_queued", lif.count, 32'd3);
      reset = 1'b1;
      lif.wr_en = 1'b1;
      lif.wr_data = 8'h99;
      #1;
      check("t6_bit0", lif.LCD_INPUT_BUS[0], 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      lif.wr_en = 1'b0;
      q.delete();
      base = pulses;
      #1;
      check("t6_count", lif.count, 32'd0);
      check("t6_bus", lif.LCD_INPUT_BUS, 32'd0);
      check("t6_ovf", lif.overflow, 32'd0);
      check("t6_terr", lif.timeout_err, 32'd0);
      check("t6_busy", lif.busy, 32'd0);
      repeat (30) @(posedge clk);
      #1;
      check("t6_no_pulse", pulses - base, 32'd0);
      check("t6_count_end", lif.count, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
